// File: rtl/alarm_bank.sv
// -----------------------------------------------------------------------------
// alarm_bank
// Bank of N_ALARM independent alarm channels that sit beside the timekeeping
// counter. Each channel stores an alarm time and has its own enable. It can be
// dismissed, snoozed for SNOOZE_MIN minute ticks, and it silences itself after
// RING_TIMEOUT_MIN minute ticks of continuous ringing (0 = never).
// The time encoding (binary or BCD) is opaque: only equality is used.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   time_in      current hour:minute from the clock core
//   min_tick     one-cycle pulse per minute rollover
//   en_in        per-channel enable (level)
//   set_sel      channel addressed by set_time and by the alarm_rd readback
//   set_time     load time_set_in into channel set_sel (forces it to IDLE)
//   time_set_in  alarm time to load
//   end_ring     dismiss every RINGING or SNOOZED channel
//   snooze       snooze every RINGING channel
//   alarm_rd     stored alarm time of channel set_sel (0 if out of range)
//   ring_vec     per-channel ringing, registered
//   snoozed_vec  per-channel snooze pending, registered
//   ring         OR of ring_vec
// -----------------------------------------------------------------------------
module alarm_bank #(
   parameter int N_ALARM          = 4,
   parameter int TIME_W           = 11,
   parameter int SNOOZE_MIN       = 5,
   parameter int RING_TIMEOUT_MIN = 10,
   localparam int SEL_W           = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [TIME_W-1:0]  time_in,
   input  logic               min_tick,
   input  logic [N_ALARM-1:0] en_in,
   input  logic [SEL_W-1:0]   set_sel,
   input  logic               set_time,
   input  logic [TIME_W-1:0]  time_set_in,
   input  logic               end_ring,
   input  logic               snooze,
   output logic [TIME_W-1:0]  alarm_rd,
   output logic [N_ALARM-1:0] ring_vec,
   output logic [N_ALARM-1:0] snoozed_vec,
   output logic               ring
);

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZED, DONE} state_t;

   localparam logic [5:0] SNOOZE_LD = 6'(SNOOZE_MIN);
   localparam bit         TMO_EN    = (RING_TIMEOUT_MIN != 0);
   localparam logic [5:0] TMO_LAST  = TMO_EN ? 6'(RING_TIMEOUT_MIN - 1) : 6'd0;

   state_t            state     [N_ALARM];
   state_t            state_nx  [N_ALARM];
   logic [5:0]        tcnt      [N_ALARM];
   logic [5:0]        tcnt_nx   [N_ALARM];
   logic [5:0]        scnt      [N_ALARM];
   logic [5:0]        scnt_nx   [N_ALARM];
   logic [TIME_W-1:0] alarm_time[N_ALARM];
   logic [N_ALARM-1:0] match;
   logic [N_ALARM-1:0] wr;

   // Per-channel compare and write decode; an out-of-range set_sel hits no
   // channel, so the write is dropped and the readback stays 0.
   always_comb begin
      alarm_rd = '0;
      for (int i = 0; i < N_ALARM; i++) begin
         match[i] = (alarm_time[i] == time_in);
         wr[i]    = set_time && (set_sel == SEL_W'(i));
         if (set_sel == SEL_W'(i)) alarm_rd = alarm_time[i];
      end
   end

   // Next-state logic. Disable and a write to the channel both force IDLE and
   // take precedence over dismiss/snooze/tick handling.
   always_comb begin
      for (int i = 0; i < N_ALARM; i++) begin
         state_nx[i] = state[i];
         tcnt_nx[i]  = tcnt[i];
         scnt_nx[i]  = scnt[i];
         if (!en_in[i] || wr[i]) begin
            state_nx[i] = IDLE;
         end else begin
            case (state[i])
               IDLE: begin
                  if (match[i]) begin
                     state_nx[i] = RINGING;
                     tcnt_nx[i]  = 6'd0;
                  end
               end
               RINGING: begin
                  if (end_ring) begin
                     state_nx[i] = DONE;
                  end else if (snooze) begin
                     state_nx[i] = SNOOZED;
                     scnt_nx[i]  = SNOOZE_LD;
                  end else if (min_tick) begin
                     if (TMO_EN && (tcnt[i] == TMO_LAST)) state_nx[i] = DONE;
                     else                                  tcnt_nx[i]  = tcnt[i] + 6'd1;
                  end
               end
               SNOOZED: begin
                  // Re-ring does not need a time match.
                  if (end_ring) begin
                     state_nx[i] = DONE;
                  end else if (min_tick) begin
                     if (scnt[i] == 6'd1) begin
                        state_nx[i] = RINGING;
                        tcnt_nx[i]  = 6'd0;
                     end else begin
                        scnt_nx[i] = scnt[i] - 6'd1;
                     end
                  end
               end
               DONE: begin
                  // Hold off until the matching minute has passed, so the
                  // channel is re-armed for the next day but not this minute.
                  if (!match[i]) state_nx[i] = IDLE;
               end
               default: state_nx[i] = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_ALARM; i++) begin
            state[i]      <= IDLE;
            tcnt[i]       <= 6'd0;
            scnt[i]       <= 6'd0;
            alarm_time[i] <= '0;
         end
         ring_vec    <= '0;
         snoozed_vec <= '0;
      end else begin
         for (int i = 0; i < N_ALARM; i++) begin
            state[i]       <= state_nx[i];
            tcnt[i]        <= tcnt_nx[i];
            scnt[i]        <= scnt_nx[i];
            if (wr[i]) alarm_time[i] <= time_set_in;
            ring_vec[i]    <= (state_nx[i] == RINGING);
            snoozed_vec[i] <= (state_nx[i] == SNOOZED);
         end
      end
   end

   assign ring = |ring_vec;

endmodule

// File: tb/tb_alarm_bank.sv
// -----------------------------------------------------------------------------
// tb_alarm_bank
// Directed bench for alarm_bank. Three instances share clock, reset and the
// control inputs: u_hex (defaults), u_nto (RING_TIMEOUT_MIN=0, same inputs as
// u_hex) and u_bcd (TIME_W=13, own time words).
// -----------------------------------------------------------------------------
module tb_alarm_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] time_in, time_set_in;
   logic [12:0] time_b, time_set_b;
   logic        min_tick, set_time, end_ring, snooze;
   logic [3:0]  en_in;
   logic [1:0]  set_sel;

   logic [10:0] rd_h, rd_n;
   logic [12:0] rd_b;
   logic [3:0]  rv_h, sv_h, rv_n, sv_n, rv_b, sv_b;
   logic        ring_h, ring_n, ring_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alarm_bank u_hex (
      .clk(clk), .rst(rst), .time_in(time_in), .min_tick(min_tick), .en_in(en_in),
      .set_sel(set_sel), .set_time(set_time), .time_set_in(time_set_in),
      .end_ring(end_ring), .snooze(snooze), .alarm_rd(rd_h), .ring_vec(rv_h),
      .snoozed_vec(sv_h), .ring(ring_h));

   alarm_bank #(.RING_TIMEOUT_MIN(0)) u_nto (
      .clk(clk), .rst(rst), .time_in(time_in), .min_tick(min_tick), .en_in(en_in),
      .set_sel(set_sel), .set_time(set_time), .time_set_in(time_set_in),
      .end_ring(end_ring), .snooze(snooze), .alarm_rd(rd_n), .ring_vec(rv_n),
      .snoozed_vec(sv_n), .ring(ring_n));

   alarm_bank #(.TIME_W(13)) u_bcd (
      .clk(clk), .rst(rst), .time_in(time_b), .min_tick(min_tick), .en_in(en_in),
      .set_sel(set_sel), .set_time(set_time), .time_set_in(time_set_b),
      .end_ring(end_ring), .snooze(snooze), .alarm_rd(rd_b), .ring_vec(rv_b),
      .snoozed_vec(sv_b), .ring(ring_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] hm(input int h, input int m);
      return 11'(h * 64 + m);
   endfunction

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic load(input logic [1:0] sel, input logic [10:0] t);
      set_sel     = sel;
      time_set_in = t;
      set_time    = 1'b1;
      step();
      set_time    = 1'b0;
   endtask

   task automatic tick();
      min_tick = 1'b1;
      step();
      min_tick = 1'b0;
   endtask

   task automatic pulse_end();
      end_ring = 1'b1;
      step();
      end_ring = 1'b0;
   endtask

   initial begin
      rst = 1'b1; time_in = '0; time_set_in = '0; time_b = 13'h1fff; time_set_b = '0;
      min_tick = 0; set_time = 0; end_ring = 0; snooze = 0; en_in = '0; set_sel = '0;
      step(); step();
      check("rst_ring_vec", rv_h, 4'b0000);
      check("rst_snoozed", sv_h, 4'b0000);
      check("rst_ring", ring_h, 1'b0);
      check("rst_alarm_rd", rd_h, 11'd0);
      rst = 1'b0;

      // Basic match, dismiss, same-minute suppression, re-arm.
      time_in = hm(7, 29);
      load(2'd0, hm(7, 30));
      check("load_rd", rd_h, hm(7, 30));
      en_in = 4'b0001;
      step();
      time_in = hm(7, 30);
      check("pre_match", rv_h, 4'b0000);
      step();
      check("match_ring", rv_h, 4'b0001);
      check("match_ring_or", ring_h, 1'b1);
      pulse_end();
      check("dismiss", rv_h, 4'b0000);
      step(); step();
      check("hold_done", rv_h, 4'b0000);
      time_in = hm(7, 31); step();
      time_in = hm(7, 30); step();
      check("rearm", rv_h, 4'b0001);

      // Snooze on ch1.
      reset_dut();
      en_in = 4'b0000;
      time_in = hm(5, 59);
      load(2'd1, hm(6, 0));
      en_in = 4'b0010;
      time_in = hm(6, 0);
      step();
      check("snz_ring", rv_h, 4'b0010);
      snooze = 1'b1; step(); snooze = 1'b0;
      check("snz_vec", sv_h, 4'b0010);
      check("snz_ring_off", ring_h, 1'b0);
      for (int k = 0; k < 4; k++) tick();
      check("snz_4tick", sv_h, 4'b0010);
      check("snz_4tick_ring", rv_h, 4'b0000);
      tick();
      check("snz_rering", rv_h, 4'b0010);
      check("snz_cleared", sv_h, 4'b0000);

      // Ring timeout on ch2; u_nto never times out.
      reset_dut();
      en_in = 4'b0000;
      time_in = hm(7, 59);
      load(2'd2, hm(8, 0));
      en_in = 4'b0100;
      time_in = hm(8, 0);
      step();
      check("tmo_ring", rv_h, 4'b0100);
      for (int k = 0; k < 9; k++) tick();
      check("tmo_9tick", rv_h, 4'b0100);
      tick();
      check("tmo_10tick", rv_h, 4'b0000);
      check("nto_10tick", rv_n, 4'b0100);
      for (int k = 0; k < 10; k++) tick();
      check("nto_20tick", rv_n, 4'b0100);
      check("tmo_done_hold", rv_h, 4'b0000);

      // Two channels on one time; end_ring + snooze together.
      reset_dut();
      en_in = 4'b0000;
      time_in = hm(9, 14);
      load(2'd0, hm(9, 15));
      load(2'd3, hm(9, 15));
      en_in = 4'b1001;
      time_in = hm(9, 15); step();
      check("dual_ring", rv_h, 4'b1001);
      pulse_end();
      check("dual_dismiss", rv_h, 4'b0000);
      time_in = hm(9, 16); step();
      time_in = hm(9, 15); step();
      check("dual_rering", rv_h, 4'b1001);
      end_ring = 1'b1; snooze = 1'b1; step(); end_ring = 1'b0; snooze = 1'b0;
      check("both_ring", rv_h, 4'b0000);
      check("both_snz", sv_h, 4'b0000);

      // set_time while ringing, then disable while snoozed.
      reset_dut();
      en_in = 4'b0000;
      time_in = hm(10, 0);
      load(2'd1, hm(10, 0));
      en_in = 4'b0010;
      step();
      check("set_ring", rv_h, 4'b0010);
      load(2'd1, hm(11, 0));
      check("set_cancel", rv_h, 4'b0000);
      check("set_rd", rd_h, hm(11, 0));
      load(2'd1, hm(10, 0));
      check("set_eq_1cyc", rv_h, 4'b0000);
      step();
      check("set_eq_2cyc", rv_h, 4'b0010);
      snooze = 1'b1; step(); snooze = 1'b0;
      check("dis_snz", sv_h, 4'b0010);
      en_in = 4'b0000; step();
      check("dis_cleared", sv_h, 4'b0000);

      // BCD instance, wrap 23:59 -> 00:00, then asynchronous reset mid-ring.
      reset_dut();
      en_in = 4'b0000;
      time_b = 13'h2358;
      time_set_b = 13'h2359;
      load(2'd0, hm(0, 0));
      check("bcd_rd", rd_b, 13'h2359);
      en_in = 4'b0001;
      time_b = 13'h2359; step();
      check("bcd_ring", rv_b, 4'b0001);
      pulse_end();
      check("bcd_dismiss", rv_b, 4'b0000);
      time_b = 13'h0000; step();
      time_b = 13'h2359; step();
      check("bcd_rearm", rv_b, 4'b0001);
      rst = 1'b1;
      #1;
      check("arst_ring_vec", rv_b, 4'b0000);
      check("arst_ring", ring_b, 1'b0);
      check("arst_rd", rd_b, 13'h0000);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
